mc_mv_ram_ctrl: RTL

//  Controller and arbiter in front of the single-port 512x20 MC MV RAM. It shares the RAM between the
//  MV writer (FME result path) and the MV reader (MC reference fetch), using valid/ack handshakes.
//  It also provides a hardware clear sequencer that zeroes all 512 entries at LCU-row start.
//  RAM control toward the macro is active-low (CEN/WEN), matching the RAM wrapper.

---
 rtl/mc_mv_ram_ctrl_pkg.sv | 21 ++
 rtl/mc_mv_ram_arb.sv | 56 +++++
 rtl/mc_mv_ram_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mc_mv_ram_ctrl_pkg.sv
// Shared definitions for the MC MV RAM controller: geometry of the
// 512x20 motion-vector RAM and the controller state encoding.
package mc_mv_ram_ctrl_pkg;

    localparam int FMV_WIDTH    = 10;
    localparam int MV_RAM_DW    = 2 * FMV_WIDTH;
    localparam int MV_RAM_AW    = 9;
    localparam int MV_RAM_DEPTH = 512;

    // SERVE arbitrates host traffic, CLEAR owns the RAM while zeroing it.
    typedef enum logic [0:0] {
        ST_SERVE = 1'b0,
        ST_CLEAR = 1'b1
    } mv_ram_state_e;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mc_mv_ram_arb.sv
// Two-way RAM arbiter: writes win over reads, except that a read which has
// lost STARVE_MAX cycles in a row is forced through. A collide_i hint
// (write and read to the same address) grants both in the same cycle.
module mc_mv_ram_arb
    import mc_mv_ram_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    input  logic collide_i,
    output logic wr_gnt_o,
    output logic rd_gnt_o
);

    localparam int              CW         = cnt_width(STARVE_MAX);
    localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          starved;

    // Grant decision: a starved read, an uncontended read, or a same-address
    // collision lets the read through; the write takes what is left.
    always_comb begin
        rd_gnt_o = 1'b0;
        wr_gnt_o = 1'b0;
        starved  = (starve_cnt_q == STARVE_LIM);
        if (en_i) begin
            rd_gnt_o = rd_req_i && (collide_i || !wr_req_i || starved);
            wr_gnt_o = wr_req_i && (collide_i || !rd_gnt_o);
        end
    end

    // Starvation count: counts cycles a read waits, saturates, and is held at
    // zero outside SERVE so the count restarts after a clear.
    always_comb begin
        starve_cnt_d = '0;
        if (en_i && rd_req_i && !rd_gnt_o) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mc_mv_ram_ctrl.sv
// Controller in front of the single-port MC MV RAM. Shares the RAM between
// the MV writer and the MV reader with valid/ack handshakes and runs a
// clear sequencer that zeroes every entry at LCU-row start.
// Optional feature macro: MC_MV_RAM_FWD_EN (same-address write-to-read
// forwarding; when undefined a colliding read simply waits).
//
// Handshake: a requester raises *_req_i with address/data stable and keeps
// them until the combinational *_ack_o is seen high at a rising clock edge;
// that edge is the transfer. Read data follows one cycle later with
// rd_vld_o. RAM controls (CEN/WEN) are active low.
module mc_mv_ram_ctrl
    import mc_mv_ram_ctrl_pkg::*;
#(
    parameter int DW         = MV_RAM_DW,
    parameter int AW         = MV_RAM_AW,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_ack_o,
    input  logic          rd_req_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_ack_o,
    output logic          rd_vld_o,
    output logic [DW-1:0] rd_data_o,
    input  logic          clr_i,
    output logic          clr_busy_o,
    output logic          clr_done_o,
    output logic          ram_cen_o,
    output logic          ram_wen_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);

    localparam logic [AW-1:0] LAST_ADDR = '1;

    mv_ram_state_e state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          clr_done_q, clr_done_d;
    logic          rd_vld_q, rd_vld_d;
    logic          serve_en;
    logic          fwd_hit;
    logic          wr_gnt;
    logic          rd_gnt;

    assign serve_en = (state_q == ST_SERVE) && !rst;

`ifdef MC_MV_RAM_FWD_EN
    logic          fwd_sel_q, fwd_sel_d;
    logic [DW-1:0] fwd_data_q, fwd_data_d;

    assign fwd_hit = wr_req_i && rd_req_i && (wr_addr_i == rd_addr_i);

    // Forward register: on a same-address collision the RAM takes the write
    // and the read is answered from a copy of the write data.
    always_comb begin
        fwd_sel_d  = wr_gnt && rd_gnt;
        fwd_data_d = fwd_data_q;
        if (wr_gnt && rd_gnt) begin
            fwd_data_d = wr_data_i;
        end
    end

    // Forward path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign rd_data_o = fwd_sel_q ? fwd_data_q : ram_data_i;
`else
    assign fwd_hit   = 1'b0;
    assign rd_data_o = ram_data_i;
`endif

    mc_mv_ram_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en_i      (serve_en),
        .wr_req_i  (wr_req_i),
        .rd_req_i  (rd_req_i),
        .collide_i (fwd_hit),
        .wr_gnt_o  (wr_gnt),
        .rd_gnt_o  (rd_gnt)
    );

    // Next state and RAM command: SERVE issues the granted access, CLEAR
    // writes zero to the address held in the clear counter every cycle.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_addr_o = '0;
        ram_data_o = '0;
        unique case (state_q)
            ST_SERVE: begin
                if (wr_gnt) begin
                    ram_cen_o  = 1'b0;
                    ram_wen_o  = 1'b0;
                    ram_addr_o = wr_addr_i;
                    ram_data_o = wr_data_i;
                end else if (rd_gnt) begin
                    ram_cen_o  = 1'b0;
                    ram_addr_o = rd_addr_i;
                end
                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                ram_cen_o  = 1'b0;
                ram_wen_o  = 1'b0;
                ram_addr_o = clr_cnt_q;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d    = ST_SERVE;
                    clr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_SERVE;
            end
        endcase
        // Keep the macro idle while reset is held, even mid-clear.
        if (rst) begin
            ram_cen_o = 1'b1;
            ram_wen_o = 1'b1;
        end
    end

    // Read-valid pipe: data from the RAM arrives one cycle after the ack.
    always_comb begin
        rd_vld_d = rd_gnt;
    end

    // State, clear counter and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SERVE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    assign wr_ack_o   = wr_gnt;
    assign rd_ack_o   = rd_gnt;
    assign rd_vld_o   = rd_vld_q;
    assign clr_busy_o = (state_q == ST_CLEAR);
    assign clr_done_o = clr_done_q;

endmodule
